// File: rtl/neureka_bitserial_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// neureka_bitserial_accumulator_pkg
// Shared types and constants for the NEUREKA bit-serial accumulator.
//   ctrl_bsacc_t  : group size (n_terms) and term signedness (signed_in)
//   flags_bsacc_t : FSM state, current term count and output-handshake pulse
//   bsacc_state_e : IDLE / ACCUM / OUTPUT
// -----------------------------------------------------------------------------
package neureka_bitserial_accumulator_pkg;

  localparam int unsigned NEUREKA_BSACC_MAX_TERMS = 8;
  // One extra bit so the counter can hold MAX_TERMS itself.
  localparam int unsigned BSACC_CNT_W = $clog2(NEUREKA_BSACC_MAX_TERMS) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } bsacc_state_e;

  typedef struct packed {
    logic [BSACC_CNT_W-1:0] n_terms;
    logic                   signed_in;
  } ctrl_bsacc_t;

  typedef struct packed {
    bsacc_state_e           state;
    logic [BSACC_CNT_W-1:0] term_cnt;
    logic                   acc_done;
  } flags_bsacc_t;

endpackage

// File: rtl/neureka_bsacc_ext.sv
// -----------------------------------------------------------------------------
// neureka_bsacc_ext
// Combinational extension of one scaled term to the accumulator width.
//   term_i      : OUT_ACC-bit term from the scale stage
//   signed_in_i : 1 = sign-extend, 0 = zero-extend
//   ext_o       : ACC-bit extended term
// -----------------------------------------------------------------------------
module neureka_bsacc_ext #(
  parameter int unsigned OUT_ACC = 16,
  parameter int unsigned ACC     = 32
) (
  input  logic [OUT_ACC-1:0]    term_i,
  input  logic                  signed_in_i,
  output logic signed [ACC-1:0] ext_o
);

  localparam int unsigned PAD = ACC - OUT_ACC;

  if (PAD == 0) begin : g_no_pad
    logic unused_sign;
    assign unused_sign = signed_in_i;
    assign ext_o       = term_i;
  end else begin : g_pad
    logic pad_bit;
    assign pad_bit = signed_in_i & term_i[OUT_ACC-1];
    assign ext_o   = {{PAD{pad_bit}}, term_i};
  end

endmodule

// File: rtl/neureka_bitserial_accumulator.sv
// -----------------------------------------------------------------------------
// neureka_bitserial_accumulator
// Sums n_eff consecutive bit-serial scaled terms into a signed accumulator and
// emits one full-precision result per group.
//   clk_i / rst_ni         : clock, synchronous active-low reset
//   test_mode_i            : no functional effect
//   enable_i               : low = stall (ACCUM frozen, OUTPUT held)
//   clear_i                : synchronous clear, highest priority
//   data_i_{valid,ready,data} : term stream from the scale stage
//   data_o_{valid,ready,data,strb} : accumulated result stream
//   ctrl_i                 : n_terms / signed_in, sampled once per group
//   flags_o                : state, term_cnt, acc_done pulse
// -----------------------------------------------------------------------------
module neureka_bitserial_accumulator
  import neureka_bitserial_accumulator_pkg::*;
#(
  parameter int unsigned OUT_ACC   = 16,
  parameter int unsigned ACC       = 32,
  parameter int unsigned MAX_TERMS = NEUREKA_BSACC_MAX_TERMS
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               test_mode_i,
  input  logic               enable_i,
  input  logic               clear_i,
  input  logic               data_i_valid,
  output logic               data_i_ready,
  input  logic [OUT_ACC-1:0] data_i_data,
  output logic               data_o_valid,
  input  logic               data_o_ready,
  output logic [ACC-1:0]     data_o_data,
  output logic [ACC/8-1:0]   data_o_strb,
  input  ctrl_bsacc_t        ctrl_i,
  output flags_bsacc_t       flags_o
);

  bsacc_state_e           state_q, state_d;
  logic signed [ACC-1:0]  acc_q;
  logic signed [ACC-1:0]  ext_term;
  logic [BSACC_CNT_W-1:0] term_cnt_q;
  logic [BSACC_CNT_W-1:0] n_eff_q;
  logic                   signed_q;
  logic                   in_take;
  logic                   last_term;
  logic                   unused_test_mode;

  assign unused_test_mode = test_mode_i;

  // n_terms == 0 means "one term per group"; anything above MAX_TERMS clamps.
  function automatic logic [BSACC_CNT_W-1:0] calc_n_eff(input logic [BSACC_CNT_W-1:0] n);
    if (n == '0)                           return BSACC_CNT_W'(1);
    else if (n > BSACC_CNT_W'(MAX_TERMS))  return BSACC_CNT_W'(MAX_TERMS);
    else                                   return n;
  endfunction

  neureka_bsacc_ext #(
    .OUT_ACC (OUT_ACC),
    .ACC     (ACC)
  ) i_ext (
    .term_i      (data_i_data),
    .signed_in_i (signed_q),
    .ext_o       (ext_term)
  );

  assign in_take   = (state_q == ACCUM) & enable_i & data_i_valid;
  assign last_term = (term_cnt_q == n_eff_q - BSACC_CNT_W'(1));

  always_comb begin
    state_d      = state_q;
    data_i_ready = 1'b0;
    data_o_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i) state_d = ACCUM;
      end
      ACCUM: begin
        data_i_ready = enable_i;
        if (in_take && last_term) state_d = OUTPUT;
      end
      OUTPUT: begin
        data_o_valid = 1'b1;
        if (data_o_ready) state_d = enable_i ? ACCUM : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end

  // Accumulator stage: group parameters are latched on group start so that
  // ctrl_i changes mid-group are ignored.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      term_cnt_q <= '0;
      n_eff_q    <= BSACC_CNT_W'(1);
      signed_q   <= 1'b0;
    end else if (clear_i) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      term_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (enable_i) begin
            acc_q      <= '0;
            term_cnt_q <= '0;
            n_eff_q    <= calc_n_eff(ctrl_i.n_terms);
            signed_q   <= ctrl_i.signed_in;
          end
        end
        ACCUM: begin
          if (in_take) begin
            acc_q      <= acc_q + ext_term;
            term_cnt_q <= term_cnt_q + BSACC_CNT_W'(1);
          end
        end
        OUTPUT: begin
          if (data_o_ready) begin
            acc_q      <= '0;
            term_cnt_q <= '0;
            n_eff_q    <= calc_n_eff(ctrl_i.n_terms);
            signed_q   <= ctrl_i.signed_in;
          end
        end
        default: ;
      endcase
    end
  end

  assign data_o_data      = acc_q;
  assign data_o_strb      = '1;
  assign flags_o.state    = state_q;
  assign flags_o.term_cnt = term_cnt_q;
  assign flags_o.acc_done = data_o_valid & data_o_ready;

endmodule

// File: tb/tb_neureka_bitserial_accumulator.sv
module tb_neureka_bitserial_accumulator;
  import neureka_bitserial_accumulator_pkg::*;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic         rst_ni, test_mode_i, enable_i, clear_i;
  logic         in_valid, in_ready;
  logic [15:0]  in_data;
  logic         out_valid, out_ready;
  logic [31:0]  out_data;
  logic [3:0]   out_strb;
  ctrl_bsacc_t  ctrl;
  flags_bsacc_t flags;

  logic         w_in_valid, w_in_ready;
  logic [15:0]  w_in_data;
  logic         w_out_valid, w_out_ready;
  logic [15:0]  w_out_data;
  logic [1:0]   w_out_strb;
  ctrl_bsacc_t  w_ctrl;
  flags_bsacc_t w_flags;

  int tests  = 0;
  int failed = 0;

  neureka_bitserial_accumulator #(.OUT_ACC(16), .ACC(32), .MAX_TERMS(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .test_mode_i(test_mode_i), .enable_i(enable_i),
    .clear_i(clear_i), .data_i_valid(in_valid), .data_i_ready(in_ready),
    .data_i_data(in_data), .data_o_valid(out_valid), .data_o_ready(out_ready),
    .data_o_data(out_data), .data_o_strb(out_strb), .ctrl_i(ctrl), .flags_o(flags)
  );

  neureka_bitserial_accumulator #(.OUT_ACC(16), .ACC(16), .MAX_TERMS(8)) dut_w (
    .clk_i(clk_i), .rst_ni(rst_ni), .test_mode_i(test_mode_i), .enable_i(enable_i),
    .clear_i(clear_i), .data_i_valid(w_in_valid), .data_i_ready(w_in_ready),
    .data_i_data(w_in_data), .data_o_valid(w_out_valid), .data_o_ready(w_out_ready),
    .data_o_data(w_out_data), .data_o_strb(w_out_strb), .ctrl_i(w_ctrl), .flags_o(w_flags)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #2;
  endtask

  task automatic send(input logic [15:0] d, input string tag);
    in_valid = 1'b1;
    in_data  = d;
    #1;
    check(tag, 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
  endtask

  logic [15:0] g1_terms [8];

  initial begin
    g1_terms = '{16'd1, 16'd2, 16'd4, 16'd8, 16'd16, 16'd32, 16'd64, 16'hFF80};
    rst_ni = 1'b0; test_mode_i = 1'b0; enable_i = 1'b0; clear_i = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    ctrl = '{n_terms: 4'd8, signed_in: 1'b1};
    w_in_valid = 1'b0; w_in_data = '0; w_out_ready = 1'b0;
    w_ctrl = '{n_terms: 4'd2, signed_in: 1'b1};
    cyc(); cyc();

    // reset state
    check("rst_state",    32'(flags.state),    32'd0);
    check("rst_in_ready", 32'(in_ready),       32'd0);
    check("rst_valid",    32'(out_valid),      32'd0);
    check("rst_data",     out_data,            32'd0);
    check("rst_term_cnt", 32'(flags.term_cnt), 32'd0);
    check("rst_acc_done", 32'(flags.acc_done), 32'd0);
    check("strb",         32'(out_strb),       32'hF);

    // basic signed 8-term group: 1+2+...+64-128 = -1
    rst_ni = 1'b1; enable_i = 1'b1;
    cyc();
    check("g1_state_accum", 32'(flags.state), 32'd1);
    for (int i = 0; i < 8; i++) begin
      send(g1_terms[i], "g1_in_ready");
      if (i == 6) check("g1_valid_early", 32'(out_valid), 32'd0);
    end
    check("g1_valid",      32'(out_valid),      32'd1);
    check("g1_data",       out_data,            32'hFFFF_FFFF);
    check("g1_in_ready_o", 32'(in_ready),       32'd0);
    check("g1_term_cnt",   32'(flags.term_cnt), 32'd8);
    check("g1_state_out",  32'(flags.state),    32'd2);
    ctrl = '{n_terms: 4'd2, signed_in: 1'b0};
    out_ready = 1'b1; #1;
    check("g1_acc_done", 32'(flags.acc_done), 32'd1);
    cyc(); out_ready = 1'b0;
    check("g1_next_state", 32'(flags.state),    32'd1);
    check("g1_cnt_clr",    32'(flags.term_cnt), 32'd0);

    // zero-extended then sign-extended pair
    send(16'hFFFF, "g2u_in"); send(16'h0001, "g2u_in");
    check("g2u_valid", 32'(out_valid), 32'd1);
    check("g2u_data",  out_data,       32'h0001_0000);
    ctrl = '{n_terms: 4'd2, signed_in: 1'b1};
    out_ready = 1'b1; cyc(); out_ready = 1'b0;
    send(16'hFFFF, "g2s_in"); send(16'h0001, "g2s_in");
    check("g2s_valid", 32'(out_valid), 32'd1);
    check("g2s_data",  out_data,       32'h0000_0000);
    ctrl = '{n_terms: 4'd3, signed_in: 1'b1};
    out_ready = 1'b1; cyc(); out_ready = 1'b0;

    // backpressure: 5+6+7 held for 4 cycles, enable low for the last two
    send(16'd5, "bp_in"); send(16'd6, "bp_in"); send(16'd7, "bp_in");
    in_valid = 1'b1; in_data = 16'd100;
    for (int k = 0; k < 4; k++) begin
      enable_i = (k < 2);
      #1;
      check("bp_valid",    32'(out_valid), 32'd1);
      check("bp_data",     out_data,       32'd18);
      check("bp_in_ready", 32'(in_ready),  32'd0);
      cyc();
    end
    enable_i = 1'b1; in_valid = 1'b0;
    ctrl = '{n_terms: 4'd4, signed_in: 1'b1};
    out_ready = 1'b1; #1;
    check("bp_acc_done",  32'(flags.acc_done), 32'd1);
    check("bp_data_hold", out_data,            32'd18);
    cyc(); out_ready = 1'b0;
    check("bp_next_state", 32'(flags.state),    32'd1);
    check("bp_cnt_clr",    32'(flags.term_cnt), 32'd0);

    // stall between terms 2 and 3
    send(16'd1, "st_in"); send(16'd1, "st_in");
    enable_i = 1'b0; in_valid = 1'b1; in_data = 16'd1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("st_in_ready", 32'(in_ready),       32'd0);
      check("st_term_cnt", 32'(flags.term_cnt), 32'd2);
      check("st_data",     out_data,            32'd2);
      cyc();
    end
    enable_i = 1'b1; in_valid = 1'b0;
    send(16'd1, "st_in"); send(16'd1, "st_in");
    check("st_valid",  32'(out_valid), 32'd1);
    check("st_result", out_data,       32'd4);
    out_ready = 1'b1; cyc(); out_ready = 1'b0;

    // clear mid-group, then a clean group, then clear during OUTPUT
    send(16'd9, "cl_in"); send(16'd9, "cl_in");
    check("cl_partial", out_data, 32'd18);
    clear_i = 1'b1; cyc(); clear_i = 1'b0;
    check("cl_state", 32'(flags.state),    32'd0);
    check("cl_cnt",   32'(flags.term_cnt), 32'd0);
    check("cl_acc",   out_data,            32'd0);
    check("cl_valid", 32'(out_valid),      32'd0);
    cyc();
    check("cl_restart", 32'(flags.state), 32'd1);
    for (int i = 0; i < 4; i++) send(16'd3, "cl_in2");
    check("cl_valid2", 32'(out_valid), 32'd1);
    check("cl_result", out_data,       32'd12);
    clear_i = 1'b1; cyc(); clear_i = 1'b0;
    check("clo_valid", 32'(out_valid),   32'd0);
    check("clo_state", 32'(flags.state), 32'd0);
    ctrl = '{n_terms: 4'd0, signed_in: 1'b1};
    cyc();
    check("n0_state", 32'(flags.state), 32'd1);

    // n_terms = 0: every term is its own group
    send(16'h1234, "n0_in");
    check("n0_valid", 32'(out_valid), 32'd1);
    check("n0_data",  out_data,       32'h0000_1234);
    out_ready = 1'b1; cyc(); out_ready = 1'b0;
    send(16'hFFFE, "n0_in");
    check("n0_valid2", 32'(out_valid), 32'd1);
    check("n0_data2",  out_data,       32'hFFFF_FFFE);
    ctrl = '{n_terms: 4'd15, signed_in: 1'b1};
    out_ready = 1'b1; cyc(); out_ready = 1'b0;

    // n_terms = 15 clamps to 8; mid-group ctrl change ignored
    send(16'd1, "cp_in");
    ctrl = '{n_terms: 4'd2, signed_in: 1'b0};
    for (int i = 1; i < 8; i++) begin
      send(16'd1, "cp_in");
      if (i == 1 || i == 6) check("cp_valid_early", 32'(out_valid), 32'd0);
    end
    check("cp_valid", 32'(out_valid), 32'd1);
    check("cp_data",  out_data,       32'd8);
    ctrl = '{n_terms: 4'd2, signed_in: 1'b1};
    out_ready = 1'b1; cyc(); out_ready = 1'b0;

    // ACC = 16 wrap: 0x7FFF + 1 -> 0x8000
    w_in_valid = 1'b1; w_in_data = 16'h7FFF; #1;
    check("w_in_ready", 32'(w_in_ready), 32'd1);
    cyc();
    w_in_data = 16'h0001;
    cyc();
    w_in_valid = 1'b0;
    check("w_valid", 32'(w_out_valid), 32'd1);
    check("w_data",  32'(w_out_data),  32'h0000_8000);

    // reset mid-ACCUM
    send(16'd5, "rm_in");
    check("rm_pre_cnt", 32'(flags.term_cnt), 32'd1);
    rst_ni = 1'b0; cyc();
    check("rm_in_ready", 32'(in_ready),       32'd0);
    check("rm_valid",    32'(out_valid),      32'd0);
    check("rm_data",     out_data,            32'd0);
    check("rm_term_cnt", 32'(flags.term_cnt), 32'd0);
    check("rm_state",    32'(flags.state),    32'd0);
    check("rm_acc_done", 32'(flags.acc_done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
